// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM state
// encoding and ALU function-select codes.
package ctrl_pkg;

  // Opcode values as they appear in the low three bits of i_code.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JUMP = 3'd5,
    OP_BNE  = 3'd6,
    OP_ADDI = 3'd7
  } opcode_e;

  // Binary 3-bit state encoding; codes 5..7 are unreachable.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // ALU operation codes driven on func_sel.
  localparam logic [1:0] FUNC_PASS = 2'b00;
  localparam logic [1:0] FUNC_ADD  = 2'b01;
  localparam logic [1:0] FUNC_SUB  = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-control-word map. Opcodes whose upper
// bits are non-zero fall outside the defined set and are flagged illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int CODE_SIZE = 6
) (
  input  logic [CODE_SIZE-1:0] op,
  output logic                 alu_k_sel,
  output logic                 reg_k_sel,
  output logic                 reg_i_sel,
  output logic [1:0]           func_sel,
  output logic                 is_nop,
  output logic                 is_mem,
  output logic                 is_store,
  output logic                 is_branch,
  output logic                 is_jump,
  output logic                 branch_ne,
  output logic                 is_wb,
  output logic                 illegal
);

  logic [CODE_SIZE-1:0] op_hi;
  opcode_e              op_lo;

  // Classify the opcode and produce its operand selects and ALU function.
  always_comb begin
    alu_k_sel = 1'b0;
    reg_k_sel = 1'b0;
    reg_i_sel = 1'b0;
    func_sel  = FUNC_ADD;
    is_nop    = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    branch_ne = 1'b0;
    is_wb     = 1'b0;
    illegal   = 1'b0;
    op_hi     = op >> 3;
    op_lo     = opcode_e'(op[2:0]);
    if (op_hi != '0) begin
      illegal = 1'b1;
    end else begin
      case (op_lo)
        OP_NOP:  is_nop = 1'b1;
        OP_ALU:  begin reg_i_sel = 1'b1; func_sel = FUNC_PASS; is_wb = 1'b1; end
        OP_LW:   begin alu_k_sel = 1'b1; is_mem = 1'b1; is_wb = 1'b1; end
        OP_SW:   begin alu_k_sel = 1'b1; reg_k_sel = 1'b1; is_mem = 1'b1; is_store = 1'b1; end
        OP_BEQ:  begin reg_k_sel = 1'b1; func_sel = FUNC_SUB; is_branch = 1'b1; end
        OP_BNE:  begin reg_k_sel = 1'b1; func_sel = FUNC_SUB; is_branch = 1'b1; branch_ne = 1'b1; end
        OP_JUMP: begin is_branch = 1'b1; is_jump = 1'b1; end
        OP_ADDI: begin alu_k_sel = 1'b1; reg_i_sel = 1'b1; is_wb = 1'b1; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with stalling memories and counts
// retired instructions (every PC update retires one instruction).
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int CODE_SIZE  = 6,
  parameter int FUNC_WIDTH = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CODE_SIZE-1:0]  i_code,
  input  logic                  zero,
  input  logic                  instr_ready,
  input  logic                  mem_ready,
  output logic                  instr_req,
  output logic                  ir_w_enable,
  output logic                  pc_w_enable,
  output logic                  pc_sel,
  output logic                  ext_sel,
  output logic                  reg_i_w_enable,
  output logic                  reg_i_sel,
  output logic                  reg_k_sel,
  output logic                  alu_k_sel,
  output logic                  ram_r_enable,
  output logic                  ram_w_enable,
  output logic [FUNC_WIDTH-1:0] func_sel,
  output logic                  illegal_op,
  output logic [CNT_WIDTH-1:0]  retired
);

  state_e               state_q, state_d;
  logic [CODE_SIZE-1:0] op_q, op_d, dec_op;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic       d_alu_k_sel, d_reg_k_sel, d_reg_i_sel;
  logic [1:0] d_func_sel;
  logic       d_is_nop, d_is_mem, d_is_store, d_is_branch;
  logic       d_is_jump, d_branch_ne, d_is_wb, d_illegal;

  // In DECODE the opcode has not been latched yet, so classify i_code directly.
  assign dec_op  = (state_q == ST_DECODE) ? i_code : op_q;
  assign retired = retired_q;

  ctrl_decode #(.CODE_SIZE(CODE_SIZE)) u_decode (
    .op        (dec_op),
    .alu_k_sel (d_alu_k_sel),
    .reg_k_sel (d_reg_k_sel),
    .reg_i_sel (d_reg_i_sel),
    .func_sel  (d_func_sel),
    .is_nop    (d_is_nop),
    .is_mem    (d_is_mem),
    .is_store  (d_is_store),
    .is_branch (d_is_branch),
    .is_jump   (d_is_jump),
    .branch_ne (d_branch_ne),
    .is_wb     (d_is_wb),
    .illegal   (d_illegal)
  );

  // State, latched opcode and retired counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and output decode; ir_w_enable is gated by rst_n so no strobe escapes during reset.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    instr_req      = 1'b0;
    ir_w_enable    = 1'b0;
    pc_w_enable    = 1'b0;
    pc_sel         = 1'b0;
    ext_sel        = 1'b0;
    reg_i_w_enable = 1'b0;
    reg_i_sel      = 1'b0;
    reg_k_sel      = 1'b0;
    alu_k_sel      = 1'b0;
    ram_r_enable   = 1'b0;
    ram_w_enable   = 1'b0;
    func_sel       = FUNC_WIDTH'(FUNC_ADD);
    illegal_op     = 1'b0;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      alu_k_sel = d_alu_k_sel;
      reg_k_sel = d_reg_k_sel;
      func_sel  = FUNC_WIDTH'(d_func_sel);
    end
    case (state_q)
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          ir_w_enable = rst_n;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d = i_code;
        if (d_is_nop || d_illegal) begin
          pc_w_enable = 1'b1;
          illegal_op  = d_illegal;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (d_is_mem) begin
          state_d = ST_MEM;
        end else if (d_is_branch) begin
          pc_w_enable = 1'b1;
          ext_sel     = d_is_jump;
          pc_sel      = d_is_jump | (zero ^ d_branch_ne);
          state_d     = ST_FETCH;
        end else if (d_is_wb) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        ram_r_enable = ~d_is_store;
        ram_w_enable = d_is_store;
        if (mem_ready) begin
          pc_w_enable = d_is_store;
          state_d     = d_is_store ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        reg_i_w_enable = 1'b1;
        reg_i_sel      = d_reg_i_sel;
        pc_w_enable    = 1'b1;
        state_d        = ST_FETCH;
      end
      default: begin
        alu_k_sel = 1'b0;
        reg_k_sel = 1'b0;
        func_sel  = '0;
        state_d   = ST_FETCH;
      end
    endcase
    retired_d = retired_q + CNT_WIDTH'(pc_w_enable);
  end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Self-checking bench for multicycle_ctrl_unit: a table of single
// instructions with chosen stall patterns, hand sequences for reset and
// counter wrap, and a randomized run against a per-instruction model.
module tb_multicycle_ctrl_unit;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_code;
  logic       zero, instr_ready, mem_ready;
  logic       instr_req, ir_w_enable, pc_w_enable, pc_sel, ext_sel;
  logic       reg_i_w_enable, reg_i_sel, reg_k_sel, alu_k_sel;
  logic       ram_r_enable, ram_w_enable, illegal_op;
  logic [1:0] func_sel;
  logic [3:0] retired;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retired = 0;

  typedef struct {
    string name;
    int op, iw, mw, z;
    int cycles, reg_cnt, reg_sel, ramr, ramw, ill, pc_sel, ext, func, alu, rk;
  } vec_t;

  typedef struct {
    int cycles, ir_cnt, reg_cnt, reg_sel, ramr, ramw, ill, pc_sel, ext, func, alu, rk;
  } rec_t;

  multicycle_ctrl_unit #(.CODE_SIZE(6), .FUNC_WIDTH(2), .CNT_WIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_code         (i_code),
    .zero           (zero),
    .instr_ready    (instr_ready),
    .mem_ready      (mem_ready),
    .instr_req      (instr_req),
    .ir_w_enable    (ir_w_enable),
    .pc_w_enable    (pc_w_enable),
    .pc_sel         (pc_sel),
    .ext_sel        (ext_sel),
    .reg_i_w_enable (reg_i_w_enable),
    .reg_i_sel      (reg_i_sel),
    .reg_k_sel      (reg_k_sel),
    .alu_k_sel      (alu_k_sel),
    .ram_r_enable   (ram_r_enable),
    .ram_w_enable   (ram_w_enable),
    .func_sel       (func_sel),
    .illegal_op     (illegal_op),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic applyStimulus(input bit ir, input bit mr, input bit z, input logic [5:0] code);
    instr_ready = ir;
    mem_ready   = mr;
    zero        = z;
    i_code      = code;
  endtask

  // Drives one instruction from FETCH until its PC update, with iw fetch
  // wait cycles and mw data-memory wait cycles, and records what it saw.
  task automatic run_instr(input int op, input int iw, input int mw, input int z, output rec_t r);
    int cyc = 0;
    int mem_seen = 0;
    bit done = 0;
    r = '{default: 0};
    while (!done && cyc < 40) begin
      applyStimulus(cyc >= iw, mem_seen >= mw, z[0], 6'(op));
      #1;
      cyc++;
      if (ir_w_enable) r.ir_cnt++;
      if (reg_i_w_enable) begin r.reg_cnt++; r.reg_sel = int'(reg_i_sel); end
      if (ram_r_enable) begin r.ramr++; mem_seen++; end
      if (ram_w_enable) begin r.ramw++; mem_seen++; end
      if (illegal_op) r.ill++;
      if (pc_w_enable) begin
        done     = 1;
        r.pc_sel = int'(pc_sel);
        r.ext    = int'(ext_sel);
        r.func   = int'(func_sel);
        r.alu    = int'(alu_k_sel);
        r.rk     = int'(reg_k_sel);
      end
      @(negedge clk);
    end
    r.cycles = done ? cyc : -1;
    if (done) exp_retired = (exp_retired + 1) % 16;
  endtask

  // Expected outputs for one cycle, from the phase the instruction is in and its opcode.
  function automatic int model_out(input int ph, input int op, input bit ir, input bit mr, input bit z);
    bit rq = 0, irw = 0, pcw = 0, pcs = 0, ext = 0, rw = 0, rs = 0;
    bit rk = 0, ak = 0, rr = 0, ww = 0, il = 0;
    int f = 1;
    if (ph == PH_F) begin
      rq = 1; irw = ir;
    end else if (ph == PH_D) begin
      if (op == 0 || op > 7) begin pcw = 1; il = (op > 7); end
    end else begin
      ak = (op == 2 || op == 3 || op == 7);
      rk = (op == 3 || op == 4 || op == 6);
      f  = (op == 1) ? 0 : ((op == 4 || op == 6) ? 3 : 1);
      if (ph == PH_E) begin
        if (op == 4) begin pcw = 1; pcs = z; end
        if (op == 6) begin pcw = 1; pcs = !z; end
        if (op == 5) begin pcw = 1; pcs = 1; ext = 1; end
      end else if (ph == PH_M) begin
        rr = (op == 2); ww = (op == 3);
        if (mr && op == 3) pcw = 1;
      end else begin
        rw = 1; rs = (op != 2); pcw = 1;
      end
    end
    return {rq, irw, pcw, pcs, ext, rw, rs, rk, ak, rr, ww, f[1:0], il};
  endfunction

  function automatic int model_next(input int ph, input int op, input bit ir, input bit mr);
    case (ph)
      PH_F:    return ir ? PH_D : PH_F;
      PH_D:    return (op == 0 || op > 7) ? PH_F : PH_E;
      PH_E:    return (op == 1 || op == 7) ? PH_W : ((op == 2 || op == 3) ? PH_M : PH_F);
      PH_M:    return !mr ? PH_M : ((op == 2) ? PH_W : PH_F);
      default: return PH_F;
    endcase
  endfunction

  initial begin
    vec_t vecs[$];
    rec_t r;
    int   seen;
    int   ph, mop, exp_v, act_v, sel;
    bit   ir, mr, z, prev_ir, prev_pc, prev_rw, prev_il;
    logic [5:0] code;

    //         name          op iw mw z  cyc reg rsel ramr ramw ill pcs ext func alu rk
    vecs.push_back(vec_t'{"alu",       1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back(vec_t'{"addi",      7, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{"lw_wait2",  2, 0, 2, 0, 7, 1, 0, 3, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back(vec_t'{"sw",        3, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1});
    vecs.push_back(vec_t'{"beq_z1",    4, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1});
    vecs.push_back(vec_t'{"bne_z1",    6, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1});
    vecs.push_back(vec_t'{"beq_z0",    4, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1});
    vecs.push_back(vec_t'{"bne_z0",    6, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1});
    vecs.push_back(vec_t'{"jump",      5, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0});
    vecs.push_back(vec_t'{"ill_3f",   63, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"ill_08",    8, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"nop_iw3",   0, 3, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back(vec_t'{"sw_iw1_m3", 3, 1, 3, 0, 8, 0, 0, 0, 4, 0, 0, 0, 1, 1, 1});
    vecs.push_back(vec_t'{"lw_nowait", 2, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0});

    // Reset with every input active: only instr_req may be high.
    rst_n = 1'b0;
    applyStimulus(1, 1, 1, 6'h3F);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_instr_req", int'(instr_req), 1);
    checkOutput("reset_ir_w", int'(ir_w_enable), 0);
    checkOutput("reset_pc_w", int'(pc_w_enable), 0);
    checkOutput("reset_illegal", int'(illegal_op), 0);
    checkOutput("reset_ram", int'({ram_r_enable, ram_w_enable, reg_i_w_enable}), 0);
    checkOutput("reset_retired", int'(retired), 0);
    applyStimulus(0, 0, 0, 6'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single instructions.
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].iw, vecs[i].mw, vecs[i].z, r);
      checkOutput({vecs[i].name, "_cycles"}, r.cycles, vecs[i].cycles);
      checkOutput({vecs[i].name, "_ir_w"}, r.ir_cnt, 1);
      checkOutput({vecs[i].name, "_reg_w"}, r.reg_cnt, vecs[i].reg_cnt);
      checkOutput({vecs[i].name, "_reg_i_sel"}, r.reg_sel, vecs[i].reg_sel);
      checkOutput({vecs[i].name, "_ram_r"}, r.ramr, vecs[i].ramr);
      checkOutput({vecs[i].name, "_ram_w"}, r.ramw, vecs[i].ramw);
      checkOutput({vecs[i].name, "_illegal"}, r.ill, vecs[i].ill);
      checkOutput({vecs[i].name, "_pc_sel"}, r.pc_sel, vecs[i].pc_sel);
      checkOutput({vecs[i].name, "_ext_sel"}, r.ext, vecs[i].ext);
      checkOutput({vecs[i].name, "_func_sel"}, r.func, vecs[i].func);
      checkOutput({vecs[i].name, "_alu_k_sel"}, r.alu, vecs[i].alu);
      checkOutput({vecs[i].name, "_reg_k_sel"}, r.rk, vecs[i].rk);
      checkOutput({vecs[i].name, "_retired"}, int'(retired), exp_retired);
    end

    // Fetch stall: five cycles without instr_ready, mem_ready high and ignored.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      #1;
      checkOutput("stall_instr_req", int'(instr_req), 1);
      checkOutput("stall_strobes", int'({ir_w_enable, pc_w_enable, reg_i_w_enable, illegal_op,
                                         ram_r_enable, ram_w_enable}), 0);
      @(negedge clk);
    end
    checkOutput("stall_retired", int'(retired), exp_retired);

    // Reset in the middle of a stalled LW memory access.
    seen = 0;
    for (int c = 0; c < 10 && seen < 2; c++) begin
      applyStimulus(1, 0, 0, 6'd2);
      #1;
      if (ram_r_enable) seen++;
      if (seen < 2) @(negedge clk);
    end
    checkOutput("lw_mem_reached", seen, 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midlw_ram_r_dropped", int'(ram_r_enable), 0);
    checkOutput("midlw_retired", int'(retired), 0);
    checkOutput("midlw_instr_req", int'(instr_req), 1);
    checkOutput("midlw_strobes", int'({pc_w_enable, reg_i_w_enable, ir_w_enable}), 0);
    applyStimulus(0, 0, 0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0;
    #1;
    checkOutput("post_reset_fetch", int'({instr_req, ir_w_enable, pc_w_enable}), 4);
    @(negedge clk);

    // 17 NOPs on a 4-bit counter: wraps 15 -> 0, ends at 1.
    for (int n = 1; n <= 17; n++) begin
      run_instr(0, 0, 0, 0, r);
      checkOutput("nop_retired", int'(retired), exp_retired);
      if (n == 15) checkOutput("nop_retired_15", int'(retired), 15);
      if (n == 16) checkOutput("nop_retired_wrap", int'(retired), 0);
    end
    checkOutput("nop_retired_end", int'(retired), 1);

    // Randomized run against the reference model, starting in FETCH.
    ph = PH_F; mop = 0;
    prev_ir = 0; prev_pc = 0; prev_rw = 0; prev_il = 0;
    for (int c = 0; c < 600; c++) begin
      ir  = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      code = (sel < 8) ? 6'(sel) : 6'($urandom_range(0, 63));
      applyStimulus(ir, mr, z, code);
      #1;
      if (ph == PH_D) mop = int'(code);
      exp_v = model_out(ph, mop, ir, mr, z);
      act_v = int'({instr_req, ir_w_enable, pc_w_enable, pc_sel, ext_sel, reg_i_w_enable,
                    reg_i_sel, reg_k_sel, alu_k_sel, ram_r_enable, ram_w_enable, func_sel,
                    illegal_op});
      checkOutput("rand_outputs", act_v, exp_v);
      checkOutput("rand_retired", int'(retired), exp_retired);
      checkOutput("rand_no_back_to_back", int'({prev_ir & ir_w_enable, prev_pc & pc_w_enable,
                                               prev_rw & reg_i_w_enable, prev_il & illegal_op}), 0);
      prev_ir = ir_w_enable; prev_pc = pc_w_enable;
      prev_rw = reg_i_w_enable; prev_il = illegal_op;
      if (exp_v[11]) exp_retired = (exp_retired + 1) % 16;
      ph = model_next(ph, mop, ir, mr);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
Multi-cycle control unit for the MIPS-style datapath. It replaces single-cycle opcode decoding with a registered FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memory, which may stall for any number of cycles. The opcode set adds BNE and ADDI to the existing NOP/ALU/LW/SW/BEQ/JUMP, flags illegal opcodes, and keeps a retired-instruction counter.

Parameters:
CODE_SIZE, 6, opcode width (opcodes zero-extended to this width)
FUNC_WIDTH, 2, width of func_sel
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_code  in  CODE_SIZE  opcode field of instruction register, valid from DECODE onward
zero  in  1  ALU zero flag, sampled in EXEC
instr_ready  in  1  instruction memory has data this cycle
mem_ready  in  1  data memory completes access this cycle
instr_req  out  1  instruction fetch request
ir_w_enable  out  1  latch instruction register
pc_w_enable  out  1  update PC
pc_sel  out  1  1 = branch/jump target, 0 = PC+1
ext_sel  out  1  1 = 26-bit immediate, 0 = 16-bit
reg_i_w_enable  out  1  register-file write strobe
reg_i_sel  out  1  write-back source: 1 = ALU, 0 = memory
reg_k_sel  out  1  1 = use ri as second register operand
alu_k_sel  out  1  1 = ALU k operand is immediate
ram_r_enable  out  1  data memory read
ram_w_enable  out  1  data memory write
func_sel  out  FUNC_WIDTH  ALU op: 00 funct passthrough, 01 add, 11 subtract
illegal_op  out  1  one-cycle pulse on undefined opcode
retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Opcodes: NOP 0, ALU 1, LW 2, SW 3, BEQ 4, JUMP 5, BNE 6, ADDI 7. All other values are illegal.
- Reset (async, rst_n low): state = FETCH, op_q = NOP, retired = 0. Outputs are decoded from registered state, so instr_req = 1 during reset and all other outputs are 0.
- FETCH:
  - instr_req = 1.
  - When instr_ready: ir_w_enable = 1 for that cycle, next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: op_q <= i_code.
  - NOP: pc_w_enable = 1, pc_sel = 0, go to FETCH.
  - Illegal: pc_w_enable = 1, pc_sel = 0, illegal_op = 1, go to FETCH.
  - Else: go to EXEC.
- EXEC: next state by op_q.
  - ALU, ADDI: go to WB.
  - LW, SW: go to MEM.
  - BEQ: pc_w_enable = 1, pc_sel = zero, go to FETCH.
  - BNE: pc_w_enable = 1, pc_sel = ~zero, go to FETCH.
  - JUMP: pc_w_enable = 1, pc_sel = 1, ext_sel = 1, go to FETCH.
- MEM:
  - LW holds ram_r_enable = 1; SW holds ram_w_enable = 1. The enable stays high until and including the mem_ready cycle.
  - On mem_ready: LW goes to WB; SW asserts pc_w_enable (pc_sel = 0) and goes to FETCH.
- WB:
  - reg_i_w_enable = 1.
  - reg_i_sel = 1 for ALU/ADDI, 0 for LW.
  - pc_w_enable = 1, pc_sel = 0, go to FETCH.
- Operand selects, held in EXEC/MEM/WB (0 in other states):
  - alu_k_sel = 1 for LW/SW/ADDI.
  - reg_k_sel = 1 for BEQ/BNE/SW.
- func_sel: in EXEC/MEM/WB, 00 for ALU, 11 for BEQ/BNE, 01 otherwise. In all other states, 01.
- Strobes: pc_w_enable, reg_i_w_enable, ir_w_enable and illegal_op are single-cycle pulses, never asserted in two consecutive cycles.
- retired: increments by 1 on every pc_w_enable cycle, including illegal and NOP. Wraps modulo 2^CNT_WIDTH with no saturation.
- Latency with zero-wait memory: NOP 2 cycles, branch/jump 3, ALU/ADDI 4, SW 4, LW 5. Each instr_ready or mem_ready wait cycle adds one.
- instr_ready outside FETCH and mem_ready outside MEM are ignored.
- Reset mid-instruction aborts immediately: no strobe is issued and the pending memory access is dropped.
- State encoding is binary, 3 bits. Unreachable codes return to FETCH on the next clock with all outputs 0.

Decomposition:
- Shared package ctrl_pkg holds opcode constants, state encoding, and func_sel codes (FUNC_PASS, FUNC_ADD, FUNC_SUB).
- Sub-module ctrl_decode is a purely combinational op_q-to-control-word map (alu_k_sel, reg_k_sel, reg_i_sel, func_sel, class flags is_mem/is_branch/is_wb/illegal).
- The FSM, strobe logic and counter live in multicycle_ctrl_unit.

Test Plan:
- Reset: assert rst_n = 0 mid-MEM of an LW -> ram_r_enable drops asynchronously, retired = 0, and after release the FSM is in FETCH with instr_req = 1.
- ALU then ADDI, instr_ready and mem_ready tied 1 -> each takes 4 cycles. reg_i_w_enable pulses in WB with reg_i_sel = 1; func_sel = 00 then 01; alu_k_sel = 0 then 1; retired = 2.
- LW with mem_ready delayed 2 cycles -> ram_r_enable high for 3 cycles, WB with reg_i_sel = 0, 7 cycles total. SW with zero wait -> ram_w_enable for 1 cycle, no reg write, 4 cycles.
- BEQ with zero = 1 and BNE with zero = 1 -> BEQ gives pc_sel = 1 and BNE gives pc_sel = 0, both with func_sel = 11 and reg_k_sel = 1. JUMP -> pc_sel = 1, ext_sel = 1.
- Opcode 6'h3F -> illegal_op pulses once in DECODE, pc_w_enable with pc_sel = 0, next instruction fetched normally.
- CNT_WIDTH = 4, run 17 NOPs -> retired wraps 15 -> 0 and reads 1 at the end. Also hold instr_ready = 0 for 5 cycles -> FSM stays in FETCH with no strobes.
